gf2_poly_div_unit: RTL and testbench



---
 rtl/gf2_poly_div_unit.sv | 187 ++++++++++++++++++
 tb/tb_gf2_poly_div_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gf2_poly_div_unit.sv
// Multi-cycle GF(2)[x] long divider: one quotient bit per enabled cycle, MSB first.
// Returns quotient/remainder with a done pulse; t_cs freezes all state.
module gf2_poly_div_unit #(
   parameter int DAT_W  = 128,
   parameter int LDAT_W = 129,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              t_cs,
   input  logic              start,
   input  logic              op_mod,
   input  logic [LDAT_W-1:0] o_dat,
   input  logic [DAT_W-1:0]  t_dat,
   output logic [DAT_W-1:0]  res_dat,
   output logic [DAT_W-1:0]  res_dat2,
   output logic              done,
   output logic              busy,
   output logic              err
);

   localparam int IDX_W = $clog2(LDAT_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [LDAT_W-1:0]  div_q, div_d;
   logic [DAT_W-1:0]   num_q, num_d;
   logic               op_mod_q, op_mod_d;
   logic [DAT_W-1:0]   rem_q, rem_d;
   logic [DAT_W-1:0]   quo_q, quo_d;
   logic [DAT_W-1:0]   res_q, res_d;
   logic [DAT_W-1:0]   res2_q, res2_d;
   logic               err_q, err_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;

   logic [IDX_W-1:0]   deg_d_s;
   logic [LDAT_W-1:0]  shift_s;
   logic               qbit_s;
   logic [DAT_W-1:0]   rem_next_s;
   logic [DAT_W-1:0]   quo_next_s;

   // Degree of the latched divisor: highest set bit wins.
   always_comb begin
      deg_d_s = '0;
      for (int i = 0; i < LDAT_W; i++) begin
         if (div_q[i]) begin
            deg_d_s = IDX_W'(i);
         end else begin
            deg_d_s = deg_d_s;
         end
      end
   end

   // One long-division step: bring down the next dividend bit and conditionally subtract.
   always_comb begin
      shift_s    = {rem_q, num_q[cnt_q]};
      qbit_s     = shift_s[deg_d_s];
      rem_next_s = shift_s[DAT_W-1:0] ^ (qbit_s ? div_q[DAT_W-1:0] : {DAT_W{1'b0}});
      quo_next_s = {quo_q[DAT_W-2:0], qbit_s};
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         div_q    <= '0;
         num_q    <= '0;
         op_mod_q <= 1'b0;
         rem_q    <= '0;
         quo_q    <= '0;
         res_q    <= '0;
         res2_q   <= '0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         num_q    <= num_d;
         op_mod_q <= op_mod_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         res_q    <= res_d;
         res2_q   <= res2_d;
         err_q    <= err_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   // Next-state logic; the zero-divisor case passes through CALC once with cnt=0.
   always_comb begin
      state_d = state_q;
      if (t_cs) begin
         case (state_q)
            IDLE:    state_d = start ? CALC : IDLE;
            CALC:    state_d = (cnt_q == {CNT_W{1'b0}}) ? DONE : CALC;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Registered status outputs follow the upcoming state.
   always_comb begin
      done_d = (state_d == DONE);
      busy_d = (state_d == CALC) || (state_d == DONE);
   end

   // Datapath updates: operand capture, division steps, result write-back.
   always_comb begin
      cnt_d    = cnt_q;
      div_d    = div_q;
      num_d    = num_q;
      op_mod_d = op_mod_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      res_d    = res_q;
      res2_d   = res2_q;
      err_d    = err_q;
      if (t_cs) begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  div_d    = o_dat;
                  num_d    = t_dat;
                  op_mod_d = op_mod;
                  rem_d    = '0;
                  quo_d    = '0;
                  if (o_dat == {LDAT_W{1'b0}}) begin
                     err_d  = 1'b1;
                     res_d  = '0;
                     res2_d = t_dat;
                     cnt_d  = '0;
                  end else begin
                     err_d  = 1'b0;
                     cnt_d  = CNT_W'(DAT_W - 1);
                  end
               end else begin
                  cnt_d = cnt_q;
               end
            end
            CALC: begin
               // A flagged zero divisor already published its results at acceptance.
               if (!err_q) begin
                  rem_d = rem_next_s;
                  quo_d = quo_next_s;
                  if (cnt_q == {CNT_W{1'b0}}) begin
                     res2_d = rem_next_s;
                     res_d  = op_mod_q ? {DAT_W{1'b0}} : quo_next_s;
                  end else begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q;
               end
            end
            DONE: begin
               cnt_d = cnt_q;
            end
            default: begin
               cnt_d = cnt_q;
            end
         endcase
      end else begin
         cnt_d = cnt_q;
      end
   end

   assign res_dat  = res_q;
   assign res_dat2 = res2_q;
   assign err      = err_q;
   assign done     = done_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_gf2_poly_div_unit.sv
// Directed bench for gf2_poly_div_unit: hand-computed quotient/remainder vectors,
// latency, stall stretching, reset abort and ignored mid-operation starts.
module tb_gf2_poly_div_unit;

   localparam int DAT_W  = 128;
   localparam int LDAT_W = 129;
   localparam int CNT_W  = 8;

   logic              clk = 1'b0;
   logic              reset_b;
   logic              t_cs;
   logic              start;
   logic              op_mod;
   logic [LDAT_W-1:0] o_dat;
   logic [DAT_W-1:0]  t_dat;
   logic [DAT_W-1:0]  res_dat;
   logic [DAT_W-1:0]  res_dat2;
   logic              done;
   logic              busy;
   logic              err;

   int n_vec = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   gf2_poly_div_unit #(
      .DAT_W (DAT_W),
      .LDAT_W(LDAT_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk     (clk),
      .reset_b (reset_b),
      .t_cs    (t_cs),
      .start   (start),
      .op_mod  (op_mod),
      .o_dat   (o_dat),
      .t_dat   (t_dat),
      .res_dat (res_dat),
      .res_dat2(res_dat2),
      .done    (done),
      .busy    (busy),
      .err     (err)
   );

   task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Issue one operation and count edges (from the accepting edge) until done is seen.
   task automatic run_op(input logic op, input logic [LDAT_W-1:0] d, input logic [DAT_W-1:0] n,
                         input int stall_at, input int pulse_at, output int lat);
      @(posedge clk); #1;
      op_mod = op;
      o_dat  = d;
      t_dat  = n;
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat   = 1;
      while (done !== 1'b1 && lat < 400) begin
         if (lat == stall_at)     t_cs = 1'b0;
         if (lat == stall_at + 5) t_cs = 1'b1;
         if (lat == pulse_at)     start = 1'b1;
         if (lat == pulse_at + 1) start = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      int                lat;
      int                extra;
      logic [LDAT_W-1:0] dmax;
      logic [DAT_W-1:0]  ones;

      reset_b = 1'b0;
      t_cs    = 1'b1;
      start   = 1'b0;
      op_mod  = 1'b0;
      o_dat   = '0;
      t_dat   = '0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_res",   256'(res_dat),  256'(0));
      check_val("rst_res2",  256'(res_dat2), 256'(0));
      check_val("rst_done",  256'(done),     256'(0));
      check_val("rst_busy",  256'(busy),     256'(0));
      check_val("rst_err",   256'(err),      256'(0));
      reset_b = 1'b1;

      // (x^4+x+1)/(x+1) = x^3+x^2+x rem 1
      run_op(1'b0, 129'h3, 128'h13, -1, -1, lat);
      check_val("c1_lat",  256'(lat),      256'(DAT_W + 1));
      check_val("c1_quo",  256'(res_dat),  256'(128'hE));
      check_val("c1_rem",  256'(res_dat2), 256'(128'h1));
      check_val("c1_err",  256'(err),      256'(0));
      check_val("c1_busy", 256'(busy),     256'(1));
      @(posedge clk); #1;
      check_val("c1_done_drop", 256'(done), 256'(0));
      check_val("c1_busy_drop", 256'(busy), 256'(0));
      check_val("c1_hold_quo",  256'(res_dat), 256'(128'hE));

      // x^4+1 = (x^2+1)^2
      run_op(1'b1, 129'h5, 128'h11, -1, -1, lat);
      check_val("mod_quo", 256'(res_dat),  256'(0));
      check_val("mod_rem", 256'(res_dat2), 256'(0));
      run_op(1'b0, 129'h5, 128'h11, -1, -1, lat);
      check_val("div_quo", 256'(res_dat),  256'(128'h5));
      check_val("div_rem", 256'(res_dat2), 256'(0));

      run_op(1'b0, 129'h0, 128'hAB, -1, -1, lat);
      check_val("z_lat",  256'(lat),      256'(2));
      check_val("z_err",  256'(err),      256'(1));
      check_val("z_quo",  256'(res_dat),  256'(0));
      check_val("z_rem",  256'(res_dat2), 256'(128'hAB));
      @(posedge clk); #1;
      check_val("z_busy_drop", 256'(busy), 256'(0));
      check_val("z_done_drop", 256'(done), 256'(0));
      check_val("z_err_hold",  256'(err),  256'(1));

      dmax      = '0;
      dmax[128] = 1'b1;
      dmax[7:0] = 8'h87;
      ones      = '1;
      run_op(1'b0, dmax, ones, -1, -1, lat);
      check_val("max_quo", 256'(res_dat),  256'(0));
      check_val("max_rem", 256'(res_dat2), 256'(ones));
      check_val("max_err", 256'(err),      256'(0));

      run_op(1'b0, 129'h1, 128'hDEAD, -1, -1, lat);
      check_val("one_quo", 256'(res_dat),  256'(128'hDEAD));
      check_val("one_rem", 256'(res_dat2), 256'(0));

      // (x^7..1)/(x^2+x+1) = x^5+x^2 rem x+1
      run_op(1'b0, 129'h7, 128'hFF, -1, -1, lat);
      check_val("ff_quo", 256'(res_dat),  256'(128'h24));
      check_val("ff_rem", 256'(res_dat2), 256'(128'h3));

      run_op(1'b0, 129'h100, 128'h5, -1, -1, lat);
      check_val("big_quo", 256'(res_dat),  256'(0));
      check_val("big_rem", 256'(res_dat2), 256'(128'h5));

      // Stall 5 cycles mid-CALC, then 3 cycles while done is high.
      run_op(1'b0, 129'h3, 128'h13, 50, -1, lat);
      check_val("st_lat", 256'(lat),      256'(DAT_W + 1 + 5));
      check_val("st_quo", 256'(res_dat),  256'(128'hE));
      check_val("st_rem", 256'(res_dat2), 256'(128'h1));
      t_cs = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_val("st_done_hold", 256'(done), 256'(1));
      end
      t_cs = 1'b1;
      @(posedge clk); #1;
      check_val("st_done_drop", 256'(done), 256'(0));

      // Abort via reset mid-operation (counter at 60).
      @(posedge clk); #1;
      op_mod = 1'b0;
      o_dat  = 129'h3;
      t_dat  = 128'h13;
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (67) @(posedge clk);
      #1;
      reset_b = 1'b0;
      #1;
      check_val("ab_res",  256'(res_dat),  256'(0));
      check_val("ab_res2", 256'(res_dat2), 256'(0));
      check_val("ab_done", 256'(done),     256'(0));
      check_val("ab_busy", 256'(busy),     256'(0));
      @(posedge clk); #1;
      reset_b = 1'b1;

      run_op(1'b0, 129'h3, 128'h13, -1, -1, lat);
      check_val("rs_lat", 256'(lat),      256'(DAT_W + 1));
      check_val("rs_quo", 256'(res_dat),  256'(128'hE));
      check_val("rs_rem", 256'(res_dat2), 256'(128'h1));

      // Start pulse during CALC must be ignored.
      run_op(1'b0, 129'h7, 128'hFF, -1, 10, lat);
      check_val("ig_lat", 256'(lat),      256'(DAT_W + 1));
      check_val("ig_quo", 256'(res_dat),  256'(128'h24));
      check_val("ig_rem", 256'(res_dat2), 256'(128'h3));
      extra = 0;
      for (int i = 0; i < 150; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) extra++;
      end
      check_val("ig_extra_done", 256'(extra), 256'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
